// File: rtl/bp_cce_mem_cmd_arbiter.sv
// Two-requester round-robin arbiter for BedRock stream memory commands.
// A grant is held for a whole message (until its last beat is accepted).
module bp_cce_mem_cmd_arbiter #(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [header_width_p-1:0] req0_header_i,
  input  logic [data_width_p-1:0]   req0_data_i,
  input  logic                      req0_v_i,
  input  logic                      req0_last_i,
  output logic                      req0_ready_and_o,

  input  logic [header_width_p-1:0] req1_header_i,
  input  logic [data_width_p-1:0]   req1_data_i,
  input  logic                      req1_v_i,
  input  logic                      req1_last_i,
  output logic                      req1_ready_and_o,

  output logic [header_width_p-1:0] mem_cmd_header_o,
  output logic [data_width_p-1:0]   mem_cmd_data_o,
  output logic                      mem_cmd_v_o,
  output logic                      mem_cmd_last_o,
  input  logic                      mem_cmd_ready_and_i,

  output logic                      grant_o,
  output logic [1:0]                state_o
);

  // Handshake: a beat moves when valid and ready_and are both high in the
  // same cycle; a valid beat is never withdrawn or switched until accepted.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e state_r, state_n;
  logic   last_served_r, last_served_n;
  logic   grant, grant_v, grant_last, hs;

  always_comb begin
    grant = ~last_served_r;
    case (state_r)
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: begin
        if (req0_v_i && !req1_v_i)      grant = 1'b0;
        else if (req1_v_i && !req0_v_i) grant = 1'b1;
        else                            grant = ~last_served_r;
      end
    endcase
    // Reset is applied combinationally too so outputs go quiet immediately.
    if (!reset_n_i) grant = 1'b0;
  end

  assign grant_v    = reset_n_i & (grant ? req1_v_i : req0_v_i);
  assign grant_last = grant ? req1_last_i : req0_last_i;
  assign hs         = grant_v & mem_cmd_ready_and_i;

  assign mem_cmd_header_o = grant ? req1_header_i : req0_header_i;
  assign mem_cmd_data_o   = grant ? req1_data_i   : req0_data_i;
  assign mem_cmd_last_o   = grant_last;
  assign mem_cmd_v_o      = grant_v;

  assign req0_ready_and_o = reset_n_i & ~grant & mem_cmd_ready_and_i;
  assign req1_ready_and_o = reset_n_i &  grant & mem_cmd_ready_and_i;

  assign grant_o = grant;
  assign state_o = state_r;

  always_comb begin
    state_n       = state_r;
    last_served_n = last_served_r;
    case (state_r)
      IDLE: begin
        if (grant_v) begin
          if (hs && grant_last) last_served_n = grant;
          else                  state_n = grant ? LOCK1 : LOCK0;
        end
      end
      LOCK0, LOCK1: begin
        if (hs && grant_last) begin
          state_n       = IDLE;
          last_served_n = grant;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
    end else begin
      state_r       <= state_n;
      last_served_r <= last_served_n;
    end
  end

endmodule

// File: tb/tb_bp_cce_mem_cmd_arbiter.sv
// Bench for bp_cce_mem_cmd_arbiter: plan-driven requesters, message-level
// round-robin reference model and per-requester scoreboard queues.
module tb_bp_cce_mem_cmd_arbiter;

  localparam int HW = 64;
  localparam int DW = 64;
  localparam int BW = HW + DW + 1;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic [HW-1:0] req0_header_i, req1_header_i, mem_cmd_header_o;
  logic [DW-1:0] req0_data_i, req1_data_i, mem_cmd_data_o;
  logic          req0_v_i, req0_last_i, req0_ready_and_o;
  logic          req1_v_i, req1_last_i, req1_ready_and_o;
  logic          mem_cmd_v_o, mem_cmd_last_o, mem_cmd_ready_and_i;
  logic          grant_o;
  logic [1:0]    state_dbg;

  // clock / reset block
  always #5 clk = ~clk;

  bp_cce_mem_cmd_arbiter #(.header_width_p(HW), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req0_header_i(req0_header_i), .req0_data_i(req0_data_i), .req0_v_i(req0_v_i),
    .req0_last_i(req0_last_i), .req0_ready_and_o(req0_ready_and_o),
    .req1_header_i(req1_header_i), .req1_data_i(req1_data_i), .req1_v_i(req1_v_i),
    .req1_last_i(req1_last_i), .req1_ready_and_o(req1_ready_and_o),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_data_o(mem_cmd_data_o),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_last_o(mem_cmd_last_o),
    .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
    .grant_o(grant_o), .state_o(state_dbg)
  );

  // scoreboard state
  logic [BW-1:0] exp_q0[$];
  logic [BW-1:0] exp_q1[$];
  int            acc_log[$];
  int            plan0[$];
  int            plan1[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic          acc0 = 1'b0;
  logic          acc1 = 1'b0;
  bit            rand_mode = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic offer(input int n, input logic last);
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    h = {$urandom, $urandom};
    h[0] = n[0];
    d = {$urandom, $urandom};
    if (n == 0) begin
      req0_header_i = h; req0_data_i = d; req0_last_i = last; req0_v_i = 1'b1;
      exp_q0.push_back({h, d, last});
    end else begin
      req1_header_i = h; req1_data_i = d; req1_last_i = last; req1_v_i = 1'b1;
      exp_q1.push_back({h, d, last});
    end
  endtask

  // plan entries: 0 = non-last beat, 1 = last beat, 2 = one idle cycle
  task automatic gen_plan(input int n);
    int len;
    len = $urandom_range(1, 4);
    if ($urandom_range(0, 3) == 0) begin
      if (n == 0) plan0.push_back(2); else plan1.push_back(2);
    end
    for (int i = 0; i < len; i++) begin
      if (i > 0 && $urandom_range(0, 4) == 0) begin
        if (n == 0) plan0.push_back(2); else plan1.push_back(2);
      end
      if (n == 0) plan0.push_back(int'(i == len - 1));
      else        plan1.push_back(int'(i == len - 1));
    end
  endtask

  task automatic service(input int n);
    logic v, a;
    int   e;
    v = (n == 0) ? req0_v_i : req1_v_i;
    a = (n == 0) ? acc0 : acc1;
    if (!v || a) begin
      e = 2;
      if (n == 0 && plan0.size() > 0)      e = plan0.pop_front();
      else if (n == 1 && plan1.size() > 0) e = plan1.pop_front();
      if (e == 2) begin
        if (n == 0) req0_v_i = 1'b0; else req1_v_i = 1'b0;
      end else begin
        offer(n, e[0]);
      end
    end
  endtask

  task automatic drive_cycle();
    if (rand_mode) begin
      if (plan0.size() == 0) gen_plan(0);
      if (plan1.size() == 0) gen_plan(1);
      mem_cmd_ready_and_i = ($urandom_range(0, 9) < 7);
    end
    service(0);
    service(1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      drive_cycle();
      step();
    end
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    req0_v_i = 1'b0; req1_v_i = 1'b0;
    req0_last_i = 1'b0; req1_last_i = 1'b0;
    req0_header_i = '0; req1_header_i = '0;
    req0_data_i = '0; req1_data_i = '0;
    mem_cmd_ready_and_i = 1'b0;
    plan0.delete(); plan1.delete();
    exp_q0.delete(); exp_q1.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    acc_log.delete();
  endtask

  task automatic check_log(input string name, input int want[$]);
    for (int i = 0; i < want.size(); i++)
      check(name, (acc_log.size() > i) ? acc_log[i] : -1, want[i]);
  endtask

  // monitor: message-level round-robin reference model and scoreboard pop
  initial begin
    int            owner;
    logic          ls;
    int            eg;
    logic          vg, have;
    logic [BW-1:0] eb;
    owner = -1;
    ls    = 1'b1;
    forever begin
      @(negedge clk);
      acc0 = req0_v_i && req0_ready_and_o;
      acc1 = req1_v_i && req1_ready_and_o;
      if (!reset_n_i) begin
        check("rst_mem_v", mem_cmd_v_o, 0);
        check("rst_ready0", req0_ready_and_o, 0);
        check("rst_ready1", req1_ready_and_o, 0);
        check("rst_grant", grant_o, 0);
        owner = -1;
        ls    = 1'b1;
      end else begin
        if (owner >= 0)                 eg = owner;
        else if (req0_v_i && !req1_v_i) eg = 0;
        else if (req1_v_i && !req0_v_i) eg = 1;
        else                            eg = ls ? 0 : 1;
        vg = (eg == 0) ? req0_v_i : req1_v_i;
        check("grant", grant_o, eg);
        check("mem_v", mem_cmd_v_o, vg);
        check("ready_granted", (eg == 0) ? req0_ready_and_o : req1_ready_and_o, mem_cmd_ready_and_i);
        check("ready_other", (eg == 0) ? req1_ready_and_o : req0_ready_and_o, 0);
        if (vg && mem_cmd_ready_and_i) begin
          have = 1'b1;
          eb   = '0;
          if (eg == 0 && exp_q0.size() > 0)      eb = exp_q0.pop_front();
          else if (eg == 1 && exp_q1.size() > 0) eb = exp_q1.pop_front();
          else                                   have = 1'b0;
          check("sb_nonempty", have, 1);
          if (have) check("beat", {mem_cmd_header_o, mem_cmd_data_o, mem_cmd_last_o}, eb);
          acc_log.push_back(eg);
          if (eb[0]) begin
            owner = -1;
            ls    = eg[0];
          end else begin
            owner = eg;
          end
        end else if (vg) begin
          owner = eg;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] held;
    int            guard;

    do_reset();
    check("reset_release_v", mem_cmd_v_o, 0);

    // alternating single-beat messages
    plan0 = '{1, 1, 1};
    plan1 = '{1, 1, 1};
    mem_cmd_ready_and_i = 1'b1;
    run(8);
    check_log("rr_single", '{0, 1, 0, 1, 0, 1});

    // 4-beat lock on req0 while req1 waits
    do_reset();
    plan0 = '{0, 0, 0, 1};
    plan1 = '{1};
    mem_cmd_ready_and_i = 1'b1;
    run(7);
    check_log("lock4", '{0, 0, 0, 0, 1});

    // stalled req1 beat is held, then accepted ahead of req0
    do_reset();
    plan1 = '{1};
    drive_cycle();
    held = exp_q1[0];
    repeat (3) begin
      step();
      check("stall_hold", {mem_cmd_header_o, mem_cmd_data_o, mem_cmd_last_o}, held);
      drive_cycle();
    end
    plan0 = '{1};
    drive_cycle();
    step();
    check("stall_hold_req0v", {mem_cmd_header_o, mem_cmd_data_o, mem_cmd_last_o}, held);
    mem_cmd_ready_and_i = 1'b1;
    run(4);
    check_log("stall_order", '{1, 0});

    // valid gap inside a req0 message keeps the lock
    do_reset();
    plan0 = '{0, 2, 2, 0, 1};
    plan1 = '{1};
    mem_cmd_ready_and_i = 1'b1;
    run(9);
    check_log("gap_lock", '{0, 0, 0, 1});

    // reset pulse during beat 2 of a req1 message
    do_reset();
    plan1 = '{0, 0, 0, 1};
    mem_cmd_ready_and_i = 1'b1;
    run(1);
    drive_cycle();
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_rst_v", mem_cmd_v_o, 0);
    check("async_rst_ready0", req0_ready_and_o, 0);
    check("async_rst_ready1", req1_ready_and_o, 0);
    check("async_rst_grant", grant_o, 0);
    do_reset();
    plan0 = '{1};
    plan1 = '{1};
    mem_cmd_ready_and_i = 1'b1;
    run(3);
    check_log("post_rst_tie", '{0, 1});

    // random traffic
    do_reset();
    rand_mode = 1'b1;
    run(10000);
    rand_mode = 1'b0;
    mem_cmd_ready_and_i = 1'b1;
    guard = 0;
    while ((plan0.size() > 0 || plan1.size() > 0 || req0_v_i || req1_v_i ||
            exp_q0.size() > 0 || exp_q1.size() > 0) && guard < 300) begin
      run(1);
      guard++;
    end
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_cce_mem_cmd_arbiter.md
BP_CCE_MEM_CMD_ARBITER -- requirements
Module: bp_cce_mem_cmd_arbiter

Interface
REQ-001 Parameter header_width_p, default 64: width of each BedRock Stream header.
REQ-002 Parameter data_width_p, default 64: width of each stream data beat.
REQ-003 clk_i  input  1: sole clock; all state updates on rising edge.
REQ-004 reset_n_i  input  1: asynchronous, active-low reset.
REQ-005 req0_header_i  input  header_width_p: requester 0 command header.
REQ-006 req0_data_i  input  data_width_p: requester 0 data beat.
REQ-007 req0_v_i  input  1: requester 0 beat valid.
REQ-008 req0_last_i  input  1: requester 0 final beat of message.
REQ-009 req0_ready_and_o  output  1: requester 0 beat accepted when high with req0_v_i.
REQ-010 req1_header_i, req1_data_i, req1_v_i, req1_last_i, req1_ready_and_o: same as REQ-005 to REQ-009, for requester 1.
REQ-011 mem_cmd_header_o  output  header_width_p: arbitrated header.
REQ-012 mem_cmd_data_o  output  data_width_p: arbitrated data beat.
REQ-013 mem_cmd_v_o  output  1: arbitrated beat valid.
REQ-014 mem_cmd_last_o  output  1: arbitrated final-beat flag.
REQ-015 mem_cmd_ready_and_i  input  1: downstream ready (ready&valid).
REQ-016 grant_o  output  1: index of the currently granted requester (diagnostic).

Function
REQ-017 State machine states: IDLE, LOCK0, LOCK1.
- LOCKn: requester n holds the output until its last beat is accepted.
REQ-018 Round-robin pointer last_served: 1 bit, records the most recently granted requester.
REQ-019 IDLE grant selection:
- Only one requester valid: that requester.
- Both valid: the requester not equal to last_served.
- Neither valid: grant = last_served flipped; outputs idle.
REQ-020 LOCKn grant: n, regardless of the other requester's valid.
REQ-021 Datapath is combinational, with zero latency:
- mem_cmd_header_o, data_o, v_o and last_o equal the granted requester's signals.
- The granted ready_and_o equals mem_cmd_ready_and_i.
- The non-granted ready_and_o is 0.
REQ-022 Handshake: a beat transfers when mem_cmd_v_o and mem_cmd_ready_and_i are both high in the same cycle.
REQ-023 IDLE transitions when the granted requester is valid:
- Handshake with last = 1: stay IDLE; last_served becomes the grant.
- Any other case (no handshake, or last = 0): go to LOCK(grant).
- Purpose: the offered beat is never switched while valid and unaccepted.
REQ-024 LOCKn transition:
- Handshake with last = 1: go to IDLE; last_served becomes n.
- Otherwise: stay in LOCKn.
REQ-025 Single-beat and multi-beat messages are both supported; the lock spans any number of beats.
REQ-026 In LOCKn, requester n deasserting valid mid-message keeps the lock; mem_cmd_v_o goes low.
REQ-027 Beats are never dropped, duplicated or interleaved between requesters within a message.
REQ-028 With both requesters continuously valid, grants alternate per message.
- Maximum wait for any requester is one message of the other.

Reset
REQ-029 Asserting reset_n_i low immediately forces:
- state = IDLE;
- last_served = 1, so requester 0 wins the first tie;
- mem_cmd_v_o = 0, req0_ready_and_o = 0, req1_ready_and_o = 0.
REQ-030 Reset asserted mid-message abandons the message; after reset release, arbitration restarts from IDLE.
REQ-031 During reset, mem_cmd_header_o, data_o and last_o are don't-care; grant_o = 0.

Verification
REQ-032 After reset, req0 and req1 both present single-beat messages with ready = 1.
- Required: req0 accepted in cycle 1, req1 in cycle 2, then req0 again.
REQ-033 req0 sends a 4-beat message (last on beat 4) while req1 is valid throughout.
- Required: 4 consecutive req0 beats, then req1.
- Required: req1_ready_and_o = 0 during all 4 req0 beats.
REQ-034 req1 is valid while ready = 0 for 3 cycles, then req0 becomes valid, then ready = 1.
- Required: req1's beat is presented unchanged for all 3 stall cycles and is accepted first.
REQ-035 req0 sends a 3-beat message with a valid gap of 2 cycles after beat 1; req1 is valid during the gap.
- Required: mem_cmd_v_o = 0 during the gap; req1 is not granted until req0's last beat.
REQ-036 reset_n_i pulsed low during beat 2 of a req1 4-beat message.
- Required: all outputs reset to 0 asynchronously.
- Required: after release, a req0/req1 tie is granted to req0.
REQ-037 Random valid/ready/last stimulus for 10k cycles with a scoreboard.
- Required: per-requester beat order is preserved; messages are never interleaved.
